// File: rtl/counting_bloom_filter_if.sv
// ----------------------------------------------------------------------------
// counting_bloom_filter_if
//   Groups the lookup, insert, remove, clear and status signals of the
//   counting Bloom filter into one bundle.
//   master : the client side. It drives lookup/insert/remove data, the strobes
//            and clear, and it reads back the hit and status flags.
//   slave  : the filter side. It is the mirror image of master.
// Ports (signals)
//   look_data_i    lookup data                 look_valid_o  lookup hit
//   incr_data_i    item to insert              incr_valid_i  insert strobe
//   decr_data_i    item to remove              decr_valid_i  remove strobe
//   filter_clear_i synchronous clear           filter_usage_o item count
//   filter_full_o  saturated/error             filter_empty_o all buckets zero
//   filter_error_o sticky wrap flag
// ----------------------------------------------------------------------------
interface counting_bloom_filter_if #(
    parameter int InpWidth  = 32,
    parameter int HashWidth = 4
);
    logic [InpWidth-1:0]  look_data_i;
    logic                 look_valid_o;
    logic [InpWidth-1:0]  incr_data_i;
    logic                 incr_valid_i;
    logic [InpWidth-1:0]  decr_data_i;
    logic                 decr_valid_i;
    logic                 filter_clear_i;
    logic [HashWidth-1:0] filter_usage_o;
    logic                 filter_full_o;
    logic                 filter_empty_o;
    logic                 filter_error_o;

    modport master (
        output look_data_i, incr_data_i, incr_valid_i,
               decr_data_i, decr_valid_i, filter_clear_i,
        input  look_valid_o, filter_usage_o, filter_full_o,
               filter_empty_o, filter_error_o
    );

    modport slave (
        input  look_data_i, incr_data_i, incr_valid_i,
               decr_data_i, decr_valid_i, filter_clear_i,
        output look_valid_o, filter_usage_o, filter_full_o,
               filter_empty_o, filter_error_o
    );
endinterface

// File: rtl/counting_bloom_filter.sv
// ----------------------------------------------------------------------------
// counting_bloom_filter
//   Counting Bloom filter for set-membership tracking with no false negatives.
//   Each item is hashed KHashes ways to bucket indices. Insert increments the
//   indicated buckets and remove decrements them. A lookup hits when every
//   bucket it indicates is nonzero. The lookup is combinational. Insert and
//   remove take effect on the next rising edge.
// Ports
//   clk_i  clock. All state changes on the rising edge.
//   rst_i  synchronous reset, active-high. It takes priority over clear.
//   bus    counting_bloom_filter_if.slave. It carries the lookup, insert,
//          remove and clear inputs and the hit, usage, full, empty and error
//          outputs.
// ----------------------------------------------------------------------------
module counting_bloom_filter #(
    parameter int KHashes     = 3,
    parameter int HashWidth   = 4,
    parameter int HashRounds  = 1,
    parameter int InpWidth    = 32,
    parameter int BucketWidth = 4,
    parameter logic [KHashes-1:0][31:0] PermSeeds = {32'd299034753, 32'd19921030, 32'd294388},
    parameter logic [KHashes-1:0][31:0] XorSeeds  = {32'd4094834, 32'd995713, 32'd65146511}
) (
    input logic                    clk_i,
    input logic                    rst_i,
    counting_bloom_filter_if.slave bus
);

    localparam int NoCounters = 2 ** HashWidth;
    localparam int NumSlices  = (InpWidth + HashWidth - 1) / HashWidth;
    localparam int SliceBits  = NumSlices * HashWidth;

    // The folding hash needs at least one bit beyond the index width.
    if (InpWidth <= HashWidth) begin : gBadWidth
        $fatal(1, "counting_bloom_filter: InpWidth must exceed HashWidth");
    end

    // A 32-bit seed is repeated across the data width, or truncated to it.
    function automatic logic [InpWidth-1:0] replicateSeed(input logic [31:0] seed);
        logic [InpWidth-1:0] rep;
        for (int b = 0; b < InpWidth; b++) begin
            rep[b] = seed[b % 32];
        end
        return rep;
    endfunction

    // One seeded hash works in three steps.
    // 1. XOR the data with the seed.
    // 2. Mix it HashRounds times. Each round rotates left by an amount taken
    //    from the permute seed and XORs in a one-bit right shift.
    // 3. Fold the result down to HashWidth bits by XORing its slices.
    // The rotate amount always falls in 1..InpWidth-1, so neither shift
    // degenerates.
    function automatic logic [HashWidth-1:0] hashIndex(input logic [InpWidth-1:0] data,
                                                       input int k);
        logic [InpWidth-1:0]  x;
        logic [SliceBits-1:0] padded;
        logic [HashWidth-1:0] idx;
        logic [63:0]          rotSum;
        int                   shiftAmt;
        x = data ^ replicateSeed(XorSeeds[k]);
        for (int r = 0; r < HashRounds; r++) begin
            rotSum   = 64'(PermSeeds[k]) + 64'(r);
            shiftAmt = int'(rotSum % 64'(InpWidth - 1)) + 1;
            x        = ((x << shiftAmt) | (x >> (InpWidth - shiftAmt))) ^ (x >> 1);
        end
        padded                 = '0;
        padded[InpWidth-1:0]   = x;
        idx                    = '0;
        for (int j = 0; j < NumSlices; j++) begin
            idx = idx ^ padded[j*HashWidth +: HashWidth];
        end
        return idx;
    endfunction

    // The bucket set an item touches is the OR of one-hot codes, one per
    // hash. When two hashes collide, the item therefore touches that bucket
    // only once.
    function automatic logic [NoCounters-1:0] indicator(input logic [InpWidth-1:0] data);
        logic [NoCounters-1:0] ind;
        ind = '0;
        for (int k = 0; k < KHashes; k++) begin
            ind[hashIndex(data, k)] = 1'b1;
        end
        return ind;
    endfunction

    logic [NoCounters-1:0][BucketWidth-1:0] r_buckets;
    logic [HashWidth-1:0]                   r_usage;
    logic                                   r_error;

    logic [NoCounters-1:0] w_lookInd;
    logic [NoCounters-1:0] w_incrInd;
    logic [NoCounters-1:0] w_decrInd;
    logic [NoCounters-1:0] w_nonzero;
    logic [NoCounters-1:0] w_saturated;
    logic [NoCounters-1:0] w_incrHit;
    logic [NoCounters-1:0] w_decrHit;
    logic [NoCounters-1:0] w_bucketUp;
    logic [NoCounters-1:0] w_bucketDown;
    logic                  w_usageUp;
    logic                  w_usageDown;
    logic                  w_wrap;

    // Hash all three data ports and summarise bucket state. The summary
    // covers which buckets hold something and which are about to overflow.
    always_comb begin
        w_lookInd   = indicator(bus.look_data_i);
        w_incrInd   = indicator(bus.incr_data_i);
        w_decrInd   = indicator(bus.decr_data_i);
        w_nonzero   = '0;
        w_saturated = '0;
        for (int i = 0; i < NoCounters; i++) begin
            w_nonzero[i]   = |r_buckets[i];
            w_saturated[i] = &r_buckets[i];
        end
    end

    // Work out the per-bucket and usage direction for this cycle. When an
    // insert and a remove touch the same bucket together, they cancel. Any
    // step that would cross the counter range counts as a wrap, and a wrap
    // raises the sticky error.
    always_comb begin
        w_incrHit    = {NoCounters{bus.incr_valid_i}} & w_incrInd;
        w_decrHit    = {NoCounters{bus.decr_valid_i}} & w_decrInd;
        w_bucketUp   = w_incrHit & ~w_decrHit;
        w_bucketDown = w_decrHit & ~w_incrHit;
        w_usageUp    = bus.incr_valid_i & ~bus.decr_valid_i;
        w_usageDown  = bus.decr_valid_i & ~bus.incr_valid_i;
        w_wrap       = (|(w_bucketUp & w_saturated)) |
                       (|(w_bucketDown & ~w_nonzero)) |
                       (w_usageUp & (&r_usage)) |
                       (w_usageDown & ~(|r_usage));
    end

    // Counter state. Reset and clear both return everything to zero, and
    // they also override any strobe issued in the same cycle. Counters wrap
    // freely. The wrap itself is recorded in the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.filter_clear_i) begin
            r_buckets <= '0;
            r_usage   <= '0;
            r_error   <= 1'b0;
        end else begin
            for (int i = 0; i < NoCounters; i++) begin
                if (w_bucketUp[i]) begin
                    r_buckets[i] <= r_buckets[i] + BucketWidth'(1);
                end else if (w_bucketDown[i]) begin
                    r_buckets[i] <= r_buckets[i] - BucketWidth'(1);
                end
            end
            if (w_usageUp) begin
                r_usage <= r_usage + HashWidth'(1);
            end else if (w_usageDown) begin
                r_usage <= r_usage - HashWidth'(1);
            end
            if (w_wrap) begin
                r_error <= 1'b1;
            end
        end
    end

    // A lookup hits when none of its indicated buckets is empty. The hit
    // reflects the current state, before any update this cycle takes effect.
    assign bus.look_valid_o   = ((w_lookInd & ~w_nonzero) == '0);
    assign bus.filter_usage_o = r_usage;
    assign bus.filter_full_o  = r_error | (|w_saturated);
    assign bus.filter_empty_o = ~(|w_nonzero);
    assign bus.filter_error_o = r_error;

endmodule

// File: tb/tb_counting_bloom_filter.sv
// ----------------------------------------------------------------------------
// tb_counting_bloom_filter
//   Directed self-checking bench for counting_bloom_filter. The sequence runs
//   as follows.
//   - Reset.
//   - Single insert, then remove.
//   - Insert and remove of the same item in the same cycle.
//   - Bucket saturation and wrap.
//   - Usage wrap.
//   - Clear.
//   - A randomised insert/remove phase. This phase is checked against a small
//     bucket model that carries its own hash.
// ----------------------------------------------------------------------------
module tb_counting_bloom_filter;

    localparam int InpWidth   = 32;
    localparam int HashWidth  = 4;
    localparam int NoCounters = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    counting_bloom_filter_if #(.InpWidth(InpWidth), .HashWidth(HashWidth)) bus ();

    counting_bloom_filter dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk_i = ~clk_i;

    // This watchdog guarantees that the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, required finish");
        $fatal(1, "[TB] timeout");
    end

    // Hash constants for the reference model. The rotate amounts are
    // 1 + (seed mod 31), worked out by hand:
    //   294388    gives 13
    //   19921030  gives 28
    //   299034753 gives 12
    logic [31:0] xorSeed [3] = '{32'd65146511, 32'd995713, 32'd4094834};
    int          rotAmt  [3] = '{13, 28, 12};

    int mBucket [NoCounters];
    int mUsage;
    bit mError;

    function automatic logic [15:0] modelInd(input logic [31:0] d);
        logic [15:0] ind;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] dbl;
        logic [3:0]  idx;
        ind = '0;
        for (int k = 0; k < 3; k++) begin
            x   = d ^ xorSeed[k];
            dbl = {x, x} << rotAmt[k];
            y   = dbl[63:32] ^ (x >> 1);
            idx = '0;
            for (int b = 0; b < 32; b++) begin
                idx[b % 4] = idx[b % 4] ^ y[b];
            end
            ind[idx] = 1'b1;
        end
        return ind;
    endfunction

    function automatic bit modelLook(input logic [31:0] d);
        logic [15:0] ind;
        ind = modelInd(d);
        for (int i = 0; i < NoCounters; i++) begin
            if (ind[i] && mBucket[i] == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit modelEmpty();
        for (int i = 0; i < NoCounters; i++) begin
            if (mBucket[i] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit modelFull();
        if (mError) return 1'b1;
        for (int i = 0; i < NoCounters; i++) begin
            if (mBucket[i] == 15) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < NoCounters; i++) mBucket[i] = 0;
        mUsage = 0;
        mError = 1'b0;
    endtask

    task automatic modelStep(input bit iv, input logic [31:0] id,
                             input bit dv, input logic [31:0] dd, input bit clr);
        logic [15:0] ii;
        logic [15:0] di;
        bit up;
        bit dn;
        if (clr) begin
            modelClear();
        end else begin
            ii = modelInd(id);
            di = modelInd(dd);
            for (int i = 0; i < NoCounters; i++) begin
                up = iv && ii[i] && !(dv && di[i]);
                dn = dv && di[i] && !(iv && ii[i]);
                if (up) begin
                    if (mBucket[i] == 15) begin mBucket[i] = 0; mError = 1'b1; end
                    else mBucket[i]++;
                end else if (dn) begin
                    if (mBucket[i] == 0) begin mBucket[i] = 15; mError = 1'b1; end
                    else mBucket[i]--;
                end
            end
            if (iv && !dv) begin
                if (mUsage == 15) begin mUsage = 0; mError = 1'b1; end
                else mUsage++;
            end else if (dv && !iv) begin
                if (mUsage == 0) begin mUsage = 15; mError = 1'b1; end
                else mUsage--;
            end
        end
    endtask

    // Drive one cycle of strobes, starting at the falling edge. The bench
    // then waits past the rising edge and releases the strobes.
    task automatic applyStimulus(input bit iv, input logic [31:0] id,
                                 input bit dv, input logic [31:0] dd, input bit clr);
        @(negedge clk_i);
        bus.incr_valid_i   = iv;
        bus.incr_data_i    = id;
        bus.decr_valid_i   = dv;
        bus.decr_data_i    = dd;
        bus.filter_clear_i = clr;
        modelStep(iv, id, dv, dd, clr);
        @(posedge clk_i);
        #1;
        bus.incr_valid_i   = 1'b0;
        bus.decr_valid_i   = 1'b0;
        bus.filter_clear_i = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkLook(input string tag, input logic [31:0] d, input bit exp);
        bus.look_data_i = d;
        #1;
        checkOutput(tag, 32'(bus.look_valid_o), 32'(exp));
    endtask

    task automatic checkFlags(input string tag, input int usage, input bit empty,
                              input bit full, input bit err);
        checkOutput({tag, ".usage"}, 32'(bus.filter_usage_o), 32'(usage));
        checkOutput({tag, ".empty"}, 32'(bus.filter_empty_o), 32'(empty));
        checkOutput({tag, ".full"},  32'(bus.filter_full_o),  32'(full));
        checkOutput({tag, ".error"}, 32'(bus.filter_error_o), 32'(err));
    endtask

    logic [31:0] held [$];

    initial begin
        bus.look_data_i    = '0;
        bus.incr_data_i    = '0;
        bus.incr_valid_i   = 1'b0;
        bus.decr_data_i    = '0;
        bus.decr_valid_i   = 1'b0;
        bus.filter_clear_i = 1'b0;
        modelClear();

        $display("[TB] reset");
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkFlags("reset", 0, 1'b1, 1'b0, 1'b0);
        checkLook("reset.look", 32'hDEADBEEF, 1'b0);

        $display("[TB] single insert and remove");
        applyStimulus(1'b1, 32'h00001234, 1'b0, 32'h0, 1'b0);
        checkFlags("ins1234", 1, 1'b0, 1'b0, 1'b0);
        checkLook("ins1234.look", 32'h00001234, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00001234, 1'b0);
        checkFlags("rem1234", 0, 1'b1, 1'b0, 1'b0);
        checkLook("rem1234.look", 32'h00001234, 1'b0);

        $display("[TB] simultaneous insert and remove");
        applyStimulus(1'b1, 32'h00CAFE00, 1'b1, 32'h00CAFE00, 1'b0);
        checkFlags("both", 0, 1'b1, 1'b0, 1'b0);
        checkLook("both.look", 32'h00CAFE00, 1'b0);

        $display("[TB] bucket saturation");
        repeat (14) applyStimulus(1'b1, 32'h00000055, 1'b0, 32'h0, 1'b0);
        checkFlags("sat14", 14, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00000055, 1'b0, 32'h0, 1'b0);
        checkFlags("sat15", 15, 1'b0, 1'b1, 1'b0);
        checkLook("sat15.look", 32'h00000055, 1'b1);
        applyStimulus(1'b1, 32'h00000055, 1'b0, 32'h0, 1'b0);
        checkFlags("sat16", 0, 1'b1, 1'b1, 1'b1);
        checkLook("sat16.look", 32'h00000055, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkFlags("clear1", 0, 1'b1, 1'b0, 1'b0);

        $display("[TB] usage wrap");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h00000100 + 32'(i), 1'b0, 32'h0, 1'b0);
        end
        checkOutput("wrap.usage", 32'(bus.filter_usage_o), 32'd0);
        checkOutput("wrap.error", 32'(bus.filter_error_o), 32'd1);
        checkOutput("wrap.full",  32'(bus.filter_full_o),  32'd1);
        checkLook("wrap.look", 32'h00000105, 1'b1);
        applyStimulus(1'b1, 32'h00000077, 1'b0, 32'h0, 1'b1);
        checkFlags("clear2", 0, 1'b1, 1'b0, 1'b0);
        checkLook("clear2.look", 32'h00000077, 1'b0);

        $display("[TB] random insert/remove");
        for (int it = 0; it < 40; it++) begin
            bit          doIncr;
            bit          doDecr;
            logic [31:0] newItem;
            logic [31:0] oldItem;
            int          pick;
            newItem = $urandom;
            oldItem = '0;
            doDecr  = (held.size() > 0) && (($urandom_range(0, 2) == 0) || (held.size() >= 8));
            doIncr  = (held.size() < 8) && (!doDecr || ($urandom_range(0, 1) == 1));
            if (doDecr) begin
                pick    = $urandom_range(0, held.size() - 1);
                oldItem = held[pick];
                held.delete(pick);
            end
            if (doIncr) held.push_back(newItem);
            applyStimulus(doIncr, newItem, doDecr, oldItem, 1'b0);
            checkFlags("rand", mUsage, modelEmpty(), modelFull(), mError);
            foreach (held[j]) checkLook("rand.held", held[j], 1'b1);
            newItem = $urandom;
            checkLook("rand.probe", newItem, modelLook(newItem));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
